// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode/funct constants and MULTU sequencer state type
// for the 5-stage MIPS pipeline hazard controller.
package pipe_ctrl_pkg;

  localparam logic [5:0] R_TYPE  = 6'b000000;
  localparam logic [5:0] LW      = 6'b100011;
  localparam logic [5:0] SW      = 6'b101011;
  localparam logic [5:0] BEQ     = 6'b000100;
  localparam logic [5:0] J       = 6'b000010;

  localparam logic [5:0] F_JR    = 6'b001000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } mul_state_t;

  function automatic logic is_multu(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op == R_TYPE) && (fn == F_MULTU);
  endfunction

  function automatic logic is_hilo_rd(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    return (op == R_TYPE) &&
           ((fn == F_MFHI) || (fn == F_MFLO));
  endfunction

endpackage

// File: rtl/mul_seq_fsm.sv
// MULTU sequencer: LOAD, MUL_CYCLES x STEP, DONE strobes
// for the shift-add multiplier; all outputs registered.
module mul_seq_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic load,
  output logic step,
  output logic done,
  output logic busy
);

  localparam int CW = $clog2(MUL_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(MUL_CYCLES - 1);

  mul_state_t    state;
  logic [CW-1:0] cnt;

  // Sequencer state, step down-counter and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      load  <= 1'b0;
      step  <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            load  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          state <= RUN;
          cnt   <= CNT_MAX;
          load  <= 1'b0;
          step  <= 1'b1;
        end
        RUN: begin
          if (cnt == '0) begin
            state <= DONE;
            step  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use / HI-LO stall, branch/jump flush and MULTU sequencing.
// Optional HAZARD_STATS_EN adds stall_cnt/flush_cnt outputs.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  id_opcode,
  input  logic [5:0]  id_funct,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_jump,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        mem_br_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        exmem_flush,
  output logic        mul_load,
  output logic        mul_step,
  output logic        mul_done,
  output logic        mul_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  logic multu;
  logic hilo_rd;
  logic load_use;
  logic hilo_stall;
  logic stall;
  logic start;

  // Hazard detection and MULTU start qualification
  always_comb begin
    multu      = is_multu(id_opcode, id_funct);
    hilo_rd    = is_hilo_rd(id_opcode, id_funct);
    load_use   = ex_mem_read && (ex_rt != 5'd0) &&
                 ((ex_rt == id_rs) || (ex_rt == id_rt));
    hilo_stall = (multu || hilo_rd) && mul_busy;
    stall      = load_use || hilo_stall;
    start      = multu && !stall &&
                 !mem_br_taken && !id_jump;
  end

  // Pipeline controls: branch flush > stall > jump flush
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_flush = 1'b0;
    unique case (1'b1)
      mem_br_taken: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_flush = 1'b1;
      end
      (!mem_br_taken && stall): begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      (!mem_br_taken && !stall && id_jump): begin
        ifid_flush = 1'b1;
      end
      default: begin
      end
    endcase
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
    end
  end

  mul_seq_fsm #(
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .load  (mul_load),
    .step  (mul_step),
    .done  (mul_done),
    .busy  (mul_busy)
  );

`ifdef HAZARD_STATS_EN
  // Saturating stall / flush cycle counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if ((ifid_flush || exmem_flush) &&
          (flush_cnt != '1))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed
// scenarios plus random traffic against a timeline model.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int M = 32;
  localparam logic [5:0] F_ADD = 6'b100000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] id_opcode = '0;
  logic [5:0] id_funct = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       id_jump = 1'b0;
  logic       ex_mem_read = 1'b0;
  logic [4:0] ex_rt = '0;
  logic       mem_br_taken = 1'b0;
  logic       pc_write, ifid_write, ifid_flush;
  logic       idex_bubble, exmem_flush;
  logic       mul_load, mul_step, mul_done, mul_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
  int unsigned m_scnt = 0;
  int unsigned m_fcnt = 0;
`endif

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int mstart = -1000;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MUL_CYCLES(M)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_opcode    (id_opcode),
    .id_funct     (id_funct),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_jump      (id_jump),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .mem_br_taken (mem_br_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_flush  (exmem_flush),
    .mul_load     (mul_load),
    .mul_step     (mul_step),
    .mul_done     (mul_done),
    .mul_busy     (mul_busy)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic check_reset_outs();
    check("rst_pc_write", 32'(pc_write), 0);
    check("rst_ifid_write", 32'(ifid_write), 0);
    check("rst_ifid_flush", 32'(ifid_flush), 0);
    check("rst_idex_bubble", 32'(idex_bubble), 0);
    check("rst_exmem_flush", 32'(exmem_flush), 0);
    check("rst_mul_load", 32'(mul_load), 0);
    check("rst_mul_step", 32'(mul_step), 0);
    check("rst_mul_done", 32'(mul_done), 0);
    check("rst_mul_busy", 32'(mul_busy), 0);
  endtask

  // One pipeline cycle: drive, check, advance the model.
  task automatic cycle(input logic [5:0] op,
                       input logic [5:0] fn,
                       input logic [4:0] rs,
                       input logic [4:0] rt,
                       input logic       jmp,
                       input logic       mrd,
                       input logic [4:0] ert,
                       input logic       br);
    bit m_busy, m_load, m_step, m_done;
    bit is_mul, is_hl, lu, stl;
    bit e_pcw, e_ifw, e_iff, e_bub, e_exf;
    id_opcode = op;
    id_funct = fn;
    id_rs = rs;
    id_rt = rt;
    id_jump = jmp;
    ex_mem_read = mrd;
    ex_rt = ert;
    mem_br_taken = br;
    #3;
    m_busy = (cyc >= mstart + 1) && (cyc <= mstart + 2 + M);
    m_load = (cyc == mstart + 1);
    m_step = (cyc >= mstart + 2) && (cyc <= mstart + 1 + M);
    m_done = (cyc == mstart + 2 + M);
    is_mul = (op == 6'd0) && (fn == 6'b011001);
    is_hl = (op == 6'd0) &&
            ((fn == 6'b010000) || (fn == 6'b010010));
    lu = mrd && (ert != 0) && ((ert == rs) || (ert == rt));
    stl = lu || ((is_mul || is_hl) && m_busy);
    e_pcw = br || !stl;
    e_ifw = e_pcw;
    e_iff = br || (!stl && jmp);
    e_bub = br || stl;
    e_exf = br;
    check("pc_write", 32'(pc_write), 32'(e_pcw));
    check("ifid_write", 32'(ifid_write), 32'(e_ifw));
    check("ifid_flush", 32'(ifid_flush), 32'(e_iff));
    check("idex_bubble", 32'(idex_bubble), 32'(e_bub));
    check("exmem_flush", 32'(exmem_flush), 32'(e_exf));
    check("mul_load", 32'(mul_load), 32'(m_load));
    check("mul_step", 32'(mul_step), 32'(m_step));
    check("mul_done", 32'(mul_done), 32'(m_done));
    check("mul_busy", 32'(mul_busy), 32'(m_busy));
`ifdef HAZARD_STATS_EN
    check("stall_cnt", stall_cnt, m_scnt);
    check("flush_cnt", flush_cnt, m_fcnt);
    if (!e_pcw) m_scnt++;
    if (e_iff || e_exf) m_fcnt++;
`endif
    if (is_mul && !br && !stl && !jmp && !m_busy)
      mstart = cyc;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(R_TYPE, F_ADD, 5'd0, 5'd0, 0, 0, 5'd0, 0);
  endtask

  initial begin
    #2;
    check_reset_outs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // cycles 0..9 idle, 0 carries the lw/add load-use pair
    cycle(R_TYPE, F_ADD, 5'd2, 5'd3, 0, 1, 5'd2, 0);
    cycle(R_TYPE, F_ADD, 5'd2, 5'd3, 0, 1, 5'd0, 0);
    idle(8);
    // MULTU at cycle 10, MFHI waits from cycle 15
    cycle(R_TYPE, F_MULTU, 5'd4, 5'd5, 0, 0, 5'd0, 0);
    idle(4);
    for (int i = 15; i <= 45; i++)
      cycle(R_TYPE, F_MFHI, 5'd0, 5'd0, 0, 0, 5'd0, 0);
    idle(3);
    // branch flush beats load-use and MULTU start
    cycle(R_TYPE, F_MULTU, 5'd6, 5'd7, 0, 1, 5'd6, 1);
    idle(2);
    // lone jump
    cycle(J, 6'd0, 5'd0, 5'd0, 1, 0, 5'd0, 0);
    // reset in the middle of RUN
    cycle(R_TYPE, F_MULTU, 5'd1, 5'd2, 0, 0, 5'd0, 0);
    idle(16);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mstart = -1000;
`ifdef HAZARD_STATS_EN
    m_scnt = 0;
    m_fcnt = 0;
`endif
    idle(40);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [5:0] op, fn;
      int r;
      r = $urandom_range(0, 9);
      op = R_TYPE;
      fn = F_ADD;
      case (r)
        0, 1: fn = F_MULTU;
        2: fn = F_MFHI;
        3: fn = F_MFLO;
        4: op = LW;
        5: op = SW;
        6: op = BEQ;
        default: fn = F_ADD;
      endcase
      cycle(op, fn,
            5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)),
            ($urandom % 12) == 0,
            ($urandom % 2) == 1,
            5'($urandom_range(0, 3)),
            ($urandom % 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
